eth_fcs_stream: RTL and testbench

- Streaming Ethernet FCS (CRC-32, IEEE 802.3) engine with a parametrised datapath width.
- Two modes, chosen by parameter:
  - GEN: passes the frame through and appends the 4-byte FCS.
  - CHECK: passes the frame through unchanged and reports whether the trailing FCS is good.
- Sits between the MAC framer/deframer and the nibble/byte PHY-side logic on the TX and RX paths.

---
 rtl/eth_fcs_stream.sv | 136 +++++++++++++
 tb/tb_eth_fcs_stream.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_stream.sv
// Streaming Ethernet FCS (reflected CRC-32) engine. MODE 0 appends the FCS to each
// frame, MODE 1 passes frames through and reports whether the trailing FCS is good.
module eth_fcs_stream #(
    parameter int DATA_W = 8,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              crc_done,
    output logic              crc_ok,
    output logic [31:0]       crc_value
);

    localparam int          FCS_BEATS = 32 / DATA_W;
    localparam logic [31:0] POLY      = 32'hEDB88320;
    localparam logic [31:0] INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] RESIDUE   = 32'hDEBB20E3;
    localparam logic [3:0]  LAST_CNT  = 4'(FCS_BEATS - 1);

    generate
        if (!(DATA_W == 4 || DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
            $error("eth_fcs_stream: DATA_W must be 4, 8, 16 or 32");
        end
        if (!(MODE == 0 || MODE == 1)) begin : g_bad_mode
            $error("eth_fcs_stream: MODE must be 0 (GEN) or 1 (CHECK)");
        end
    endgenerate

    typedef enum logic {
        DATA = 1'b0,
        FCS  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [31:0] crc_q;
    logic [31:0] fcs_q;
    logic [31:0] crc_nxt;
    logic        out_free;
    logic        fcs_load;
    logic        accept;

    // Bit-serial reflected CRC over one beat, bit 0 first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DATA_W-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < DATA_W; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_nxt   = crc_step(crc_q, in_data);
    assign crc_value = crc_q;

    // Valid/ready: a beat transfers on a rising edge where valid && ready are both
    // high; the sender holds valid and payload stable until then, and ready never
    // looks at valid on the same side.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        fcs_load = 1'b0;
        out_free = !out_valid || out_ready;
        case (state_q)
            DATA: begin
                in_ready = out_free;
                if (MODE == 0 && in_valid && out_free && in_last) begin
                    state_d = FCS;
                end
            end
            FCS: begin
                fcs_load = out_free;
                if (out_free && cnt_q == LAST_CNT) begin
                    state_d = DATA;
                end
            end
            default: state_d = DATA;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DATA;
            cnt_q     <= 4'd0;
            crc_q     <= INIT;
            fcs_q     <= 32'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            crc_done  <= 1'b0;
            crc_ok    <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_done <= 1'b0;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_last  <= (MODE != 0) && in_last;
                if (in_last) begin
                    // Reload here so the next frame can start on the very next cycle.
                    crc_q <= INIT;
                    if (MODE == 0) begin
                        fcs_q <= ~crc_nxt;
                        cnt_q <= 4'd0;
                    end else begin
                        crc_done <= 1'b1;
                        crc_ok   <= (crc_nxt == RESIDUE);
                    end
                end else begin
                    crc_q <= crc_nxt;
                end
            end else if (fcs_load) begin
                // FCS leaves low bits first; shifting keeps the next beat at the bottom.
                out_valid <= 1'b1;
                out_data  <= fcs_q[DATA_W-1:0];
                out_last  <= (cnt_q == LAST_CNT);
                fcs_q     <= fcs_q >> DATA_W;
                cnt_q     <= cnt_q + 4'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_fcs_stream.sv
// Directed bench for eth_fcs_stream: GEN at 4/8/16-bit beats, CHECK at 8-bit beats,
// against the "123456789" check value 0xCBF43926 and a reference CRC model.
module tb_eth_fcs_stream;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // GEN, 8-bit
    logic g8_in_valid = 0, g8_in_ready, g8_in_last = 0, g8_out_valid, g8_out_ready = 1, g8_out_last;
    logic g8_crc_done, g8_crc_ok;
    logic [7:0] g8_in_data = 0, g8_out_data;
    logic [31:0] g8_crc_value;
    // GEN, 4-bit
    logic g4_in_valid = 0, g4_in_ready, g4_in_last = 0, g4_out_valid, g4_out_ready = 1, g4_out_last;
    logic g4_crc_done, g4_crc_ok;
    logic [3:0] g4_in_data = 0, g4_out_data;
    logic [31:0] g4_crc_value;
    // CHECK, 8-bit
    logic c8_in_valid = 0, c8_in_ready, c8_in_last = 0, c8_out_valid, c8_out_ready = 1, c8_out_last;
    logic c8_crc_done, c8_crc_ok;
    logic [7:0] c8_in_data = 0, c8_out_data;
    logic [31:0] c8_crc_value;
    // GEN, 16-bit
    logic g16_in_valid = 0, g16_in_ready, g16_in_last = 0, g16_out_valid, g16_out_ready = 1, g16_out_last;
    logic g16_crc_done, g16_crc_ok;
    logic [15:0] g16_in_data = 0, g16_out_data;
    logic [31:0] g16_crc_value;
    logic g16_rand_en = 0;

    eth_fcs_stream #(.DATA_W(8), .MODE(0)) u_gen8 (
        .clk(clk), .reset(reset), .in_valid(g8_in_valid), .in_ready(g8_in_ready), .in_data(g8_in_data),
        .in_last(g8_in_last), .out_valid(g8_out_valid), .out_ready(g8_out_ready), .out_data(g8_out_data),
        .out_last(g8_out_last), .crc_done(g8_crc_done), .crc_ok(g8_crc_ok), .crc_value(g8_crc_value));
    eth_fcs_stream #(.DATA_W(4), .MODE(0)) u_gen4 (
        .clk(clk), .reset(reset), .in_valid(g4_in_valid), .in_ready(g4_in_ready), .in_data(g4_in_data),
        .in_last(g4_in_last), .out_valid(g4_out_valid), .out_ready(g4_out_ready), .out_data(g4_out_data),
        .out_last(g4_out_last), .crc_done(g4_crc_done), .crc_ok(g4_crc_ok), .crc_value(g4_crc_value));
    eth_fcs_stream #(.DATA_W(8), .MODE(1)) u_chk8 (
        .clk(clk), .reset(reset), .in_valid(c8_in_valid), .in_ready(c8_in_ready), .in_data(c8_in_data),
        .in_last(c8_in_last), .out_valid(c8_out_valid), .out_ready(c8_out_ready), .out_data(c8_out_data),
        .out_last(c8_out_last), .crc_done(c8_crc_done), .crc_ok(c8_crc_ok), .crc_value(c8_crc_value));
    eth_fcs_stream #(.DATA_W(16), .MODE(0)) u_gen16 (
        .clk(clk), .reset(reset), .in_valid(g16_in_valid), .in_ready(g16_in_ready), .in_data(g16_in_data),
        .in_last(g16_in_last), .out_valid(g16_out_valid), .out_ready(g16_out_ready), .out_data(g16_out_data),
        .out_last(g16_out_last), .crc_done(g16_crc_done), .crc_ok(g16_crc_ok), .crc_value(g16_crc_value));

    // Scoreboard: expected {last, data} beats, zero-extended to 16 data bits.
    logic [16:0] exp_q[$];
    logic [8:0]  g8_rx_q[$];
    logic [4:0]  g4_rx_q[$];
    logic [8:0]  c8_rx_q[$];
    logic [16:0] g16_rx_q[$];
    logic        c8_done_q[$];

    logic [7:0] fcs8[4]   = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    logic [3:0] fcs4[8]   = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    logic [7:0] chk13[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                              8'h26, 8'h39, 8'hF4, 8'hCB};

    always @(negedge clk) begin
        if (g8_out_valid && g8_out_ready) g8_rx_q.push_back({g8_out_last, g8_out_data});
        if (g4_out_valid && g4_out_ready) g4_rx_q.push_back({g4_out_last, g4_out_data});
        if (c8_out_valid && c8_out_ready) c8_rx_q.push_back({c8_out_last, c8_out_data});
        if (g16_out_valid && g16_out_ready) g16_rx_q.push_back({g16_out_last, g16_out_data});
        if (c8_crc_done) c8_done_q.push_back(c8_crc_ok);
    end

    always @(posedge clk) begin
        #1;
        g16_out_ready = g16_rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Reference CRC: reflected CRC-32, one bit at a time, bit 0 first.
    function automatic logic [31:0] crc_model16(input logic [31:0] c, input logic [15:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 16; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else r = r >> 1;
        end
        return r;
    endfunction

    // Driver tasks: entered and left at posedge+1; return once the beat was taken.
    task automatic send_g8(input logic [7:0] d, input logic last);
        logic acc;
        int n;
        acc = 0; n = 0;
        g8_in_data = d; g8_in_last = last; g8_in_valid = 1;
        while (!acc && n < 200) begin
            @(negedge clk); acc = g8_in_ready; @(posedge clk); #1; n++;
        end
        g8_in_valid = 0; g8_in_last = 0;
        if (!acc) begin n_checks++; $display("FAIL g8_accept_timeout got=stalled exp=accepted"); end
    endtask

    task automatic send_g4(input logic [3:0] d, input logic last);
        logic acc;
        int n;
        acc = 0; n = 0;
        g4_in_data = d; g4_in_last = last; g4_in_valid = 1;
        while (!acc && n < 200) begin
            @(negedge clk); acc = g4_in_ready; @(posedge clk); #1; n++;
        end
        g4_in_valid = 0; g4_in_last = 0;
        if (!acc) begin n_checks++; $display("FAIL g4_accept_timeout got=stalled exp=accepted"); end
    endtask

    task automatic send_c8(input logic [7:0] d, input logic last);
        logic acc;
        int n;
        acc = 0; n = 0;
        c8_in_data = d; c8_in_last = last; c8_in_valid = 1;
        while (!acc && n < 200) begin
            @(negedge clk); acc = c8_in_ready; @(posedge clk); #1; n++;
        end
        c8_in_valid = 0; c8_in_last = 0;
        if (!acc) begin n_checks++; $display("FAIL c8_accept_timeout got=stalled exp=accepted"); end
    endtask

    task automatic send_g16(input logic [15:0] d, input logic last);
        logic acc;
        int n;
        acc = 0; n = 0;
        g16_in_data = d; g16_in_last = last; g16_in_valid = 1;
        while (!acc && n < 200) begin
            @(negedge clk); acc = g16_in_ready; @(posedge clk); #1; n++;
        end
        g16_in_valid = 0; g16_in_last = 0;
        if (!acc) begin n_checks++; $display("FAIL g16_accept_timeout got=stalled exp=accepted"); end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (g8_out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", g8_out_valid); else n_pass++;
        n_checks++; if (g8_out_last !== 1'b0) $display("FAIL rst_out_last got=%b exp=0", g8_out_last); else n_pass++;
        n_checks++; if (g8_out_data !== 8'h00) $display("FAIL rst_out_data got=%h exp=00", g8_out_data); else n_pass++;
        n_checks++; if (g8_crc_value !== 32'hFFFFFFFF) $display("FAIL rst_crc_value got=%h exp=ffffffff", g8_crc_value); else n_pass++;
        n_checks++; if (c8_crc_done !== 1'b0) $display("FAIL rst_crc_done got=%b exp=0", c8_crc_done); else n_pass++;
        n_checks++; if (c8_crc_ok !== 1'b0) $display("FAIL rst_crc_ok got=%b exp=0", c8_crc_ok); else n_pass++;
        reset = 0;
        @(posedge clk); #1;
        n_checks++; if (g8_in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", g8_in_ready); else n_pass++;
    endtask

    task automatic test_gen8();
        logic [16:0] got, exp_v;
        logic [7:0] b;
        int idx;
        g8_rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            b = 8'h31 + 8'(i);
            exp_q.push_back({1'b0, 8'h00, b});
            send_g8(b, i == 8);
        end
        @(negedge clk);
        n_checks++; if (g8_in_ready !== 1'b0) $display("FAIL gen8_in_ready_fcs got=%b exp=0", g8_in_ready); else n_pass++;
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 8'h00, fcs8[i]});
        for (int k = 0; k < 1000 && g8_rx_q.size() < 13; k++) @(negedge clk);
        idx = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got = 'x;
            if (g8_rx_q.size() > 0) begin b = g8_rx_q[0][7:0]; got = {g8_rx_q[0][8], 8'h00, b}; void'(g8_rx_q.pop_front()); end
            n_checks++; if (got !== exp_v) $display("FAIL gen8_beat%0d got=%h exp=%h", idx, got, exp_v); else n_pass++;
            idx++;
        end
        n_checks++; if (g8_rx_q.size() != 0) $display("FAIL gen8_extra_beats got=%0d exp=0", g8_rx_q.size()); else n_pass++;
        n_checks++; if (g8_crc_value !== 32'hFFFFFFFF) $display("FAIL gen8_crc_reload got=%h exp=ffffffff", g8_crc_value); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_gen4();
        logic [16:0] got, exp_v;
        logic [7:0] b;
        logic [3:0] nib;
        int idx;
        g4_rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            b = 8'h31 + 8'(i);
            exp_q.push_back({1'b0, 12'h000, b[3:0]});
            exp_q.push_back({1'b0, 12'h000, b[7:4]});
            send_g4(b[3:0], 1'b0);
            send_g4(b[7:4], i == 8);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, 12'h000, fcs4[i]});
        for (int k = 0; k < 1000 && g4_rx_q.size() < 26; k++) @(negedge clk);
        idx = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got = 'x;
            if (g4_rx_q.size() > 0) begin nib = g4_rx_q[0][3:0]; got = {g4_rx_q[0][4], 12'h000, nib}; void'(g4_rx_q.pop_front()); end
            n_checks++; if (got !== exp_v) $display("FAIL gen4_beat%0d got=%h exp=%h", idx, got, exp_v); else n_pass++;
            idx++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_check8();
        logic [16:0] got, exp_v;
        logic [7:0] b;
        logic ok;
        int idx;
        c8_rx_q.delete(); c8_done_q.delete(); exp_q.delete();
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back({i == 12, 8'h00, chk13[i]});
            send_c8(chk13[i], i == 12);
        end
        for (int k = 0; k < 200 && (c8_done_q.size() < 1 || c8_rx_q.size() < 13); k++) @(negedge clk);
        ok = (c8_done_q.size() > 0) ? c8_done_q.pop_front() : 1'bx;
        n_checks++; if (ok !== 1'b1) $display("FAIL chk_good_verdict got=%b exp=1", ok); else n_pass++;
        idx = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got = 'x;
            if (c8_rx_q.size() > 0) begin b = c8_rx_q[0][7:0]; got = {c8_rx_q[0][8], 8'h00, b}; void'(c8_rx_q.pop_front()); end
            n_checks++; if (got !== exp_v) $display("FAIL chk_pass_beat%0d got=%h exp=%h", idx, got, exp_v); else n_pass++;
            idx++;
        end
        repeat (3) @(negedge clk);
        n_checks++; if (c8_crc_ok !== 1'b1) $display("FAIL chk_ok_hold got=%b exp=1", c8_crc_ok); else n_pass++;
        n_checks++; if (c8_crc_done !== 1'b0) $display("FAIL chk_done_pulse got=%b exp=0", c8_crc_done); else n_pass++;
        @(posedge clk); #1;
        // Same frame with bit 0 of the fifth byte flipped.
        for (int i = 0; i < 13; i++) begin
            b = chk13[i];
            if (i == 4) b[0] = ~b[0];
            send_c8(b, i == 12);
        end
        for (int k = 0; k < 200 && c8_done_q.size() < 1; k++) @(negedge clk);
        ok = (c8_done_q.size() > 0) ? c8_done_q.pop_front() : 1'bx;
        n_checks++; if (ok !== 1'b0) $display("FAIL chk_bad_verdict got=%b exp=0", ok); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [16:0] got, exp_v;
        logic [7:0] b;
        logic ok;
        int idx;
        c8_rx_q.delete(); c8_done_q.delete(); exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 13; i++) begin
                exp_q.push_back({i == 12, 8'h00, chk13[i]});
                send_c8(chk13[i], i == 12);
            end
        end
        for (int k = 0; k < 200 && (c8_done_q.size() < 2 || c8_rx_q.size() < 26); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++; if (c8_done_q.size() != 2) $display("FAIL b2b_done_count got=%0d exp=2", c8_done_q.size()); else n_pass++;
        for (int f = 0; f < 2; f++) begin
            ok = (c8_done_q.size() > 0) ? c8_done_q.pop_front() : 1'bx;
            n_checks++; if (ok !== 1'b1) $display("FAIL b2b_verdict%0d got=%b exp=1", f, ok); else n_pass++;
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got = 'x;
            if (c8_rx_q.size() > 0) begin b = c8_rx_q[0][7:0]; got = {c8_rx_q[0][8], 8'h00, b}; void'(c8_rx_q.pop_front()); end
            n_checks++; if (got !== exp_v) $display("FAIL b2b_beat%0d got=%h exp=%h", idx, got, exp_v); else n_pass++;
            idx++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gen16_backpressure();
        logic [16:0] got, exp_v;
        logic [31:0] crc, fcs;
        logic [15:0] d;
        int len, idx;
        g16_rx_q.delete(); exp_q.delete();
        g16_rand_en = 1;
        for (int f = 0; f < 3; f++) begin
            len = $urandom_range(1, 5);
            crc = 32'hFFFFFFFF;
            for (int i = 0; i < len; i++) begin
                d = 16'($urandom_range(0, 65535));
                crc = crc_model16(crc, d);
                exp_q.push_back({1'b0, d});
                send_g16(d, i == len - 1);
            end
            @(negedge clk);
            n_checks++; if (g16_in_ready !== 1'b0) $display("FAIL g16_in_ready_fcs%0d got=%b exp=0", f, g16_in_ready); else n_pass++;
            @(posedge clk); #1;
            fcs = ~crc;
            exp_q.push_back({1'b0, fcs[15:0]});
            exp_q.push_back({1'b1, fcs[31:16]});
        end
        for (int k = 0; k < 2000 && g16_rx_q.size() < exp_q.size(); k++) @(negedge clk);
        g16_rand_en = 0;
        idx = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got = (g16_rx_q.size() > 0) ? g16_rx_q.pop_front() : 'x;
            n_checks++; if (got !== exp_v) $display("FAIL g16_beat%0d got=%h exp=%h", idx, got, exp_v); else n_pass++;
            idx++;
        end
        repeat (3) @(negedge clk);
        n_checks++; if (g16_rx_q.size() != 0) $display("FAIL g16_extra_beats got=%0d exp=0", g16_rx_q.size()); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_fcs();
        logic [16:0] got, exp_v;
        logic [7:0] b;
        int idx;
        send_g8(8'h41, 1'b0);
        send_g8(8'h42, 1'b1);
        reset = 1;
        @(posedge clk); #1;
        n_checks++; if (g8_out_valid !== 1'b0) $display("FAIL rstfcs_out_valid got=%b exp=0", g8_out_valid); else n_pass++;
        n_checks++; if (g8_crc_value !== 32'hFFFFFFFF) $display("FAIL rstfcs_crc got=%h exp=ffffffff", g8_crc_value); else n_pass++;
        reset = 0;
        g8_rx_q.delete(); exp_q.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            b = 8'h31 + 8'(i);
            exp_q.push_back({1'b0, 8'h00, b});
            send_g8(b, i == 8);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 8'h00, fcs8[i]});
        for (int k = 0; k < 1000 && g8_rx_q.size() < 13; k++) @(negedge clk);
        idx = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got = 'x;
            if (g8_rx_q.size() > 0) begin b = g8_rx_q[0][7:0]; got = {g8_rx_q[0][8], 8'h00, b}; void'(g8_rx_q.pop_front()); end
            n_checks++; if (got !== exp_v) $display("FAIL rstfcs_beat%0d got=%h exp=%h", idx, got, exp_v); else n_pass++;
            idx++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_gen8();
        test_gen4();
        test_check8();
        test_back_to_back();
        test_gen16_backpressure();
        test_reset_in_fcs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
